// File: rtl/alioth_sys_bus_if.sv
// Master-side and slave-side bundles of the alioth system bus.
// The interconnect takes the slave view of the masters and the master view of the slaves.
interface alioth_sys_bus_mst_if #(
    parameter int NUM_MASTERS = 2,
    parameter int DATA_W      = 32
);
    logic [NUM_MASTERS-1:0]        m_req_i;
    logic [NUM_MASTERS-1:0]        m_we_i;
    logic [NUM_MASTERS*32-1:0]     m_addr_i;
    logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i;
    logic [NUM_MASTERS-1:0]        m_gnt_o;
    logic [NUM_MASTERS-1:0]        m_rvalid_o;
    logic [DATA_W-1:0]             m_rdata_o;
    logic                          m_err_o;

    modport master (
        output m_req_i, m_we_i, m_addr_i, m_wdata_i,
        input  m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o
    );
    modport slave (
        input  m_req_i, m_we_i, m_addr_i, m_wdata_i,
        output m_gnt_o, m_rvalid_o, m_rdata_o, m_err_o
    );
endinterface

interface alioth_sys_bus_slv_if #(
    parameter int NUM_SLAVES = 4,
    parameter int DATA_W     = 32
);
    logic [NUM_SLAVES-1:0]        s_req_o;
    logic                         s_we_o;
    logic [31:0]                  s_addr_o;
    logic [DATA_W-1:0]            s_wdata_o;
    logic [NUM_SLAVES-1:0]        s_rvalid_i;
    logic [NUM_SLAVES*DATA_W-1:0] s_rdata_i;

    modport master (
        output s_req_o, s_we_o, s_addr_o, s_wdata_o,
        input  s_rvalid_i, s_rdata_i
    );
    modport slave (
        input  s_req_o, s_we_o, s_addr_o, s_wdata_o,
        output s_rvalid_i, s_rdata_i
    );
endinterface

// File: rtl/alioth_sys_bus.sv
// Single-outstanding round-robin system bus interconnect, top-nibble slave decode.
// Optional WAIT watchdog enabled by defining ALIOTH_BUS_TIMEOUT_EN.
module alioth_sys_bus #(
    parameter int NUM_MASTERS    = 2,
    parameter int NUM_SLAVES     = 4,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    alioth_sys_bus_mst_if.slave  mst,
    alioth_sys_bus_slv_if.master slv
);
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR} state_e;

    if (TIMEOUT_CYCLES < 2) begin : g_tmo_chk
        $error("alioth_sys_bus: TIMEOUT_CYCLES must be >= 2");
    end

    state_e                  state_q, state_d;
    logic [MW-1:0]           last_q, last_d;
    logic [MW-1:0]           win_q, win_d;
    logic [3:0]              sel_q, sel_d;
    logic                    we_q, we_d;
    logic [31:0]             addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d;
    logic [NUM_MASTERS-1:0]  gnt_q, gnt_d;
    logic [NUM_MASTERS-1:0]  rvalid_q, rvalid_d;
    logic                    err_q, err_d;
    logic [DATA_W-1:0]       mrdata_q, mrdata_d;
    logic [NUM_SLAVES-1:0]   sreq_q, sreq_d;
`ifdef ALIOTH_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
`endif

    logic                    found;
    logic [MW-1:0]           pick;
    logic                    hit;
    logic [DATA_W-1:0]       sdat;

    // Round-robin: first requester at or after last_grant+1, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            for (int j = 0; j < NUM_MASTERS; j++) begin
                if (!found && mst.m_req_i[j] &&
                    j == (int'(last_q) + i) % NUM_MASTERS) begin
                    found = 1'b1;
                    pick  = MW'(j);
                end
            end
        end
    end

    always_comb begin
        hit  = 1'b0;
        sdat = '0;
        for (int s = 0; s < NUM_SLAVES; s++) begin
            if (sel_q == 4'(s)) begin
                hit  = slv.s_rvalid_i[s];
                sdat = slv.s_rdata_i[s*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        win_d    = win_q;
        sel_d    = sel_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        gnt_d    = '0;
        rvalid_d = '0;
        err_d    = 1'b0;
        mrdata_d = '0;
        sreq_d   = '0;
`ifdef ALIOTH_BUS_TIMEOUT_EN
        cnt_d    = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    for (int m = 0; m < NUM_MASTERS; m++) begin
                        if (pick == MW'(m)) begin
                            addr_d   = mst.m_addr_i[m*32 +: 32];
                            we_d     = mst.m_we_i[m];
                            wdata_d  = mst.m_wdata_i[m*DATA_W +: DATA_W];
                            gnt_d[m] = 1'b1;
                        end
                    end
                    win_d   = pick;
                    last_d  = pick;
                    sel_d   = addr_d[31:28];
                    state_d = (int'(addr_d[31:28]) < NUM_SLAVES) ? REQ : ERR;
                end
            end
            REQ: begin
                for (int s = 0; s < NUM_SLAVES; s++) begin
                    sreq_d[s] = (sel_q == 4'(s));
                end
`ifdef ALIOTH_BUS_TIMEOUT_EN
                cnt_d   = '0;
`endif
                state_d = WAIT;
            end
            WAIT: begin
                if (hit) begin
                    rdata_d = sdat;
                    state_d = RESP;
                end
`ifdef ALIOTH_BUS_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                for (int m = 0; m < NUM_MASTERS; m++) begin
                    rvalid_d[m] = (win_q == MW'(m));
                end
                mrdata_d = rdata_q;
                state_d  = IDLE;
            end
            ERR: begin
                for (int m = 0; m < NUM_MASTERS; m++) begin
                    rvalid_d[m] = (win_q == MW'(m));
                end
                err_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_q   <= MW'(NUM_MASTERS - 1);
            win_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            err_q    <= 1'b0;
            mrdata_q <= '0;
            sreq_q   <= '0;
`ifdef ALIOTH_BUS_TIMEOUT_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            win_q    <= win_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            mrdata_q <= mrdata_d;
            sreq_q   <= sreq_d;
`ifdef ALIOTH_BUS_TIMEOUT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign mst.m_gnt_o    = gnt_q;
    assign mst.m_rvalid_o = rvalid_q;
    assign mst.m_rdata_o  = mrdata_q;
    assign mst.m_err_o    = err_q;
    assign slv.s_req_o    = sreq_q;
    assign slv.s_we_o     = we_q;
    assign slv.s_addr_o   = addr_q;
    assign slv.s_wdata_o  = wdata_q;
endmodule
